// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the sequential chunked comparator: op codes, FSM
// encoding, configuration checks and result-flag selection.
package alu_cmp_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLT  = 3'b000;
    localparam logic [OP_W-1:0] OP_SLTU = 3'b001;
    localparam logic [OP_W-1:0] OP_SEQ  = 3'b010;
    localparam logic [OP_W-1:0] OP_SNE  = 3'b011;
    localparam logic [OP_W-1:0] OP_SGE  = 3'b100;
    localparam logic [OP_W-1:0] OP_SGEU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int  DEF_WIDTH    = 32;
    localparam int  DEF_CHUNK    = 8;
    localparam bit  CHUNK_DIV_OK = (DEF_CHUNK >= 1) && ((DEF_WIDTH % DEF_CHUNK) == 0);

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_SLT) || (op == OP_SGE);
    endfunction

    // Reserved codes fall through to 0.
    function automatic logic flag_of(input logic [OP_W-1:0] op, input logic lt, input logic eq);
        logic f;
        f = 1'b0;
        case (op)
            OP_SLT, OP_SLTU: f = lt;
            OP_SGE, OP_SGEU: f = !lt;
            OP_SEQ:          f = eq;
            OP_SNE:          f = !eq;
            default:         f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_cmp_seq_if.sv
// Request/response bundle for alu_cmp_seq; the EX stage is the master.
interface alu_cmp_seq_if
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [OP_W-1:0]  op_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c_o;

    modport master (
        output flush, in_valid, a_i, b_i, op_i, out_ready,
        input  in_ready, out_valid, c_o
    );

    modport slave (
        input  flush, in_valid, a_i, b_i, op_i, out_ready,
        output in_ready, out_valid, c_o
    );

endinterface

// File: rtl/alu_cmp_chunk.sv
// One CHUNK-bit unsigned magnitude compare slice.
module alu_cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/alu_cmp_seq.sv
// Multi-cycle MSB-first set-less-than/equal unit, CHUNK bits per cycle.
// Define ALU_CMP_EARLY_EXIT_EN to stop scanning at the first differing chunk.
module alu_cmp_seq
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_cmp_seq_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << (WIDTH - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("alu_cmp_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             decided_q, decided_d;
    logic             flag_q, flag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic             cur_lt, cur_eq;
    logic             scan_lt, scan_dec, scan_last;

    always_comb begin
        a_sl = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_sl = b_q[int'(idx_q) * CHUNK +: CHUNK];
    end

    alu_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_sl),
        .b  (b_sl),
        .lt (cur_lt),
        .eq (cur_eq)
    );

    // Only the first unequal chunk decides lt; later chunks are ignored.
    always_comb begin
        scan_lt   = decided_q ? lt_q : (!cur_eq && cur_lt);
        scan_dec  = decided_q || !cur_eq;
`ifdef ALU_CMP_EARLY_EXIT_EN
        scan_last = (idx_q == '0) || !cur_eq;
`else
        scan_last = (idx_q == '0);
`endif
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        lt_d        = lt_q;
        decided_d   = decided_q;
        flag_d      = flag_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    a_d        = op_is_signed(bus.op_i) ? (bus.a_i ^ SIGN_FLIP) : bus.a_i;
                    b_d        = op_is_signed(bus.op_i) ? (bus.b_i ^ SIGN_FLIP) : bus.b_i;
                    op_d       = bus.op_i;
                    idx_d      = IDXW'(NCHUNK - 1);
                    lt_d       = 1'b0;
                    decided_d  = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                lt_d      = scan_lt;
                decided_d = scan_dec;
                if (scan_last) begin
                    flag_d      = flag_of(op_q, scan_lt, !scan_dec);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase

        // Flush beats everything, including a same-cycle request.
        if (bus.flush) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            lt_q        <= 1'b0;
            decided_q   <= 1'b0;
            flag_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            lt_q        <= lt_d;
            decided_q   <= decided_d;
            flag_q      <= flag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c_o       = WIDTH'(flag_q);

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Directed and random checks of alu_cmp_seq (WIDTH=32, CHUNK=8).
module tb_alu_cmp_seq;
    import alu_cmp_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmp_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef ALU_CMP_EARLY_EXIT_EN
        for (int i = 0; i < NCHUNK; i++)
            if (a[(NCHUNK-1-i)*CHUNK +: CHUNK] != b[(NCHUNK-1-i)*CHUNK +: CHUNK])
                return i + 1;
        return NCHUNK;
`else
        return NCHUNK;
`endif
    endfunction

    function automatic logic ref_flag(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return $signed(a) < $signed(b);
            3'd1:    return a < b;
            3'd2:    return a == b;
            3'd3:    return a != b;
            3'd4:    return $signed(a) >= $signed(b);
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Issue one op, measure latency, optionally stall the consumer, then drain.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic exp_f, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op_i     = op;
        bus.a_i      = a;
        bus.b_i      = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_i      = ~a;
        bus.b_i      = a;
        check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
        check({tag, "_c_o"}, 64'(bus.c_o), 64'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_c"}, 64'(bus.c_o), 64'(exp_f));
            check({tag, "_hold_r"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drain_v"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_drain_r"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic seen;
        logic [WIDTH-1:0] ra, rb;
        logic [2:0]       rop;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.op_i      = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(bus.in_ready), 64'd1);
        check("rst_vld", 64'(bus.out_valid), 64'd0);
        check("rst_c_o", 64'(bus.c_o), 64'd0);
        rst = 1'b0;

        run_op("slt_neg",  3'd0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        run_op("sltu_neg", 3'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op("seq_eq",   3'd2, 32'h1234_5678, 32'h1234_5678, 1'b1, 0);
        run_op("sne_eq",   3'd3, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        run_op("sge_lt",   3'd4, 32'h0000_0005, 32'h0000_0007, 1'b0, 3);
        run_op("sgeu_max", 3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op("slt_m1",   3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op("sge_eqn",  3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("sne_lsb",  3'd3, 32'h0000_0001, 32'h0000_0000, 1'b1, 0);
        run_op("sltu_mid", 3'd1, 32'h0012_0000, 32'h0013_0000, 1'b1, 0);
        run_op("rsv_111",  3'd7, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("rsv_110",  3'd6, 32'h0000_0001, 32'h0000_0002, 1'b0, 0);

        // Flush while scanning: the result must never appear.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_i     = 3'd5;
        bus.a_i      = 32'hFF00_0000;
        bus.b_i      = 32'h0F00_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        check("fl_acc", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check("fl_vld", 64'(bus.out_valid), 64'd0);
        check("fl_rdy", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (NCHUNK + 2) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("fl_never", 64'(seen), 64'd0);

        // Same-cycle request and flush: request dropped.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("fl_same_rdy", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (NCHUNK + 2) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("fl_same_never", 64'(seen), 64'd0);

        // Reset mid-scan also clears the held flag.
        run_op("pre_rst", 3'd0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        check("pre_rst_c_o", 64'(bus.c_o), 64'd1);
        bus.in_valid = 1'b1;
        bus.op_i     = 3'd2;
        bus.a_i      = 32'hA5A5_A5A5;
        bus.b_i      = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
        check("mid_rst_vld", 64'(bus.out_valid), 64'd0);
        check("mid_rst_c_o", 64'(bus.c_o), 64'd0);

        for (int n = 0; n < 2000; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, WIDTH - 1));
                default: rb = $urandom;
            endcase
            run_op("rnd", rop, ra, rb, ref_flag(rop, ra, rb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
